// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and helpers for the iterative ALU
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_OR      = 4'b0001,
    OP_ADD     = 4'b0010,
    OP_XOR     = 4'b0011,
    OP_SLL     = 4'b0100,
    OP_SRL     = 4'b0101,
    OP_SUB     = 4'b0110,
    OP_SLT     = 4'b0111,
    OP_EQ      = 4'b1000,
    OP_SRA     = 4'b1001,
    OP_NE      = 4'b1010,
    OP_SLT_ALT = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// rtl/alu_single_cycle.sv - combinational result for the one-cycle ops
// Shift codes return 0 here; the iterative path in the top owns them.
module alu_single_cycle
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  logic lt;
  logic eq;

  assign lt = $signed(a_i) < $signed(b_i);
  assign eq = (a_i == b_i);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:             y_o = a_i & b_i;
      OP_OR:              y_o = a_i | b_i;
      OP_ADD:             y_o = a_i + b_i;
      OP_XOR:             y_o = a_i ^ b_i;
      OP_SUB:             y_o = a_i - b_i;
      OP_SLT, OP_SLT_ALT: y_o = {{(DATA_W-1){1'b0}}, lt};
      OP_EQ:              y_o = {{(DATA_W-1){1'b0}}, eq};
      OP_NE:              y_o = {{(DATA_W-1){1'b0}}, ~eq};
      default:            y_o = '0;
    endcase
  end

endmodule

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - handshaked ALU with one-bit-per-cycle shifter
// Single-cycle ops finish at accept; shifts walk the result register n times.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero
);

  localparam int SHAMT_W = $clog2(DATA_W);

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   sc_y;
  logic [SHAMT_W-1:0]  shamt;

  alu_single_cycle #(.DATA_W(DATA_W)) u_single (
    .op_i (Operation),
    .a_i  (SrcA),
    .b_i  (SrcB),
    .y_o  (sc_y)
  );

  assign shamt     = SrcB[SHAMT_W-1:0];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUResult = res_q;
  assign Zero      = zero_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = Operation;
          if (is_shift_op(Operation)) begin
            res_d = SrcA;
            if (shamt != '0) begin
              cnt_d   = shamt;
              state_d = SHIFT;
            end else begin
              state_d = DONE;
            end
          end else begin
            res_d   = sc_y;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        // SRA replicates the MSB each step, which is always the original sign.
        case (op_q)
          OP_SLL:  res_d = {res_q[DATA_W-2:0], 1'b0};
          OP_SRL:  res_d = {1'b0, res_q[DATA_W-1:1]};
          default: res_d = {res_q[DATA_W-1], res_q[DATA_W-1:1]};
        endcase
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= (res_d == '0);
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - directed self-checking bench for iterative_alu
module tb_iterative_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  iterative_alu #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure latency to out_valid.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int lat;
    @(negedge clk);
    check_eq({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    Operation = 4'b0010;
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, ALUResult, exp_res);
    check_eq({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp_zero});
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int late;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Operation = 4'b0;
    SrcA      = '0;
    SrcB      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy", {31'b0, in_ready}, 32'd1);
    check_eq("rst_vld", {31'b0, out_valid}, 32'd0);
    check_eq("rst_res", ALUResult, 32'd0);
    check_eq("rst_zero", {31'b0, Zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add",  4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    run_op("sub",  4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("slt",  4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run_op("slt2", 4'b1111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    run_op("eq",   4'b1000, 32'd9, 32'd9, 32'd1, 1'b0, 1);
    run_op("ne",   4'b1010, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    run_op("and",  4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
    run_op("or",   4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
    run_op("sra",  4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5);
    run_op("srl",  4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5);
    run_op("srap", 4'b1001, 32'h7000_0000, 32'd1, 32'h3800_0000, 1'b0, 2);
    run_op("sll",  4'b0100, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 32);
    run_op("sll0", 4'b0100, 32'h0000_00AB, 32'h0000_0020, 32'h0000_00AB, 1'b0, 1);
    run_op("unk",  4'b1100, 32'h1234_5678, 32'd1, 32'd0, 1'b1, 1);

    // Back-pressure: result must hold and new requests must be ignored.
    out_ready = 1'b0;
    run_op_stall();

    // Reset in the middle of a 20-step shift.
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0100;
    SrcA      = 32'd1;
    SrcB      = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_vld", {31'b0, out_valid}, 32'd0);
    check_eq("mid_rst_res", ALUResult, 32'd0);
    check_eq("mid_rst_rdy", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    late = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) late++;
    end
    check_eq("no_late_result", late, 0);
    run_op("post_rst", 4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic run_op_stall();
    int lat;
    logic [31:0] bad;
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0011;
    SrcA      = 32'hFF00_FF00;
    SrcB      = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    Operation = 4'b0010;
    SrcA      = 32'd2;
    SrcB      = 32'd3;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("xor_lat", lat, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ALUResult !== 32'hF00F_F00F || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check_eq("stall_hold", bad, 0);
    check_eq("stall_res", ALUResult, 32'hF00F_F00F);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("release_idle", {30'b0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("next_vld", {31'b0, out_valid}, 32'd1);
    check_eq("next_res", ALUResult, 32'd5);
    @(posedge clk); #1;
    check_eq("next_idle", {31'b0, in_ready}, 32'd1);
  endtask

endmodule
